sdram_arbit_resp: RTL and testbench

//  Controller-side responder for the FIFO controller's SDRAM request interface. Arbitrates

---
 rtl/sdram_arbit_resp.sv | 202 ++++++++++++++++++++
 tb/tb_sdram_arbit_resp.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit_resp.sv
// SDRAM write/read/refresh arbiter and ack-window responder for the FIFO controller.
// Define ARB_RR_EN for round-robin write/read tie-breaking (default: write wins).
module sdram_arbit_resp #(
    parameter int unsigned T_RCD   = 3,
    parameter int unsigned T_RP    = 3,
    parameter int unsigned T_RC    = 8,
    parameter int unsigned CAS_LAT = 3,
    parameter int unsigned REF_PER = 750
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic        sdram_wr_req,
    input  logic [23:0] sdram_wr_addr,
    input  logic [9:0]  wr_burst_len,
    input  logic [15:0] sdram_wr_data,
    output logic        sdram_wr_ack,
    input  logic        sdram_rd_req,
    input  logic [23:0] sdram_rd_addr,
    input  logic [9:0]  rd_burst_len,
    output logic        sdram_rd_ack,
    output logic [15:0] sdram_rd_data,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_a,
    input  logic [15:0] sdram_dq_in,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe
);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_BST = 4'b0110;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    localparam int RW = $clog2(REF_PER);
    localparam logic [RW-1:0] REF_LAST = RW'(REF_PER - 1);
    localparam logic [10:0] RCD_LAST = 11'(T_RCD - 2);
    localparam logic [10:0] RP_LAST  = 11'(T_RP - 2);
    localparam logic [10:0] RC_LAST  = 11'(T_RC - 2);
    localparam logic [10:0] CAS      = 11'(CAS_LAT);

    typedef enum logic [3:0] {
        S_IDLE, S_REF, S_REF_W, S_ACT, S_RCD_W, S_WR,
        S_RD, S_RD_W, S_BST, S_PRE, S_PRE_W
    } state_t;

    state_t        state, state_nx;
    logic [10:0]   cnt;
    logic [RW-1:0] ref_cnt;
    logic          ref_pend;
    logic          op_wr;
    logic [23:0]   addr_q;
    logic [9:0]    len_q;
    logic [10:0]   len_m1;
    logic          wr_ok, rd_ok, pick_wr, pick_rd, grant;

`ifdef ARB_RR_EN
    logic          last_wr;
`endif

    assign wr_ok = sdram_wr_req && (wr_burst_len != 10'd0);
    assign rd_ok = sdram_rd_req && (rd_burst_len != 10'd0);

`ifdef ARB_RR_EN
    assign pick_wr = wr_ok && (!rd_ok || !last_wr);
`else
    assign pick_wr = wr_ok;
`endif
    assign pick_rd = rd_ok && !pick_wr;

    assign grant  = (state == S_IDLE) && init_done && !ref_pend
                  && (pick_wr || pick_rd);
    assign len_m1 = {1'b0, len_q} - 11'd1;

    assign sdram_dq_out = sdram_wr_data;

    // State register; cnt counts cycles spent in the current state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state || state == S_IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 11'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            len_q   <= '0;
            op_wr   <= 1'b0;
`ifdef ARB_RR_EN
            last_wr <= 1'b0;
`endif
        end else if (grant) begin
            addr_q  <= pick_wr ? sdram_wr_addr : sdram_rd_addr;
            len_q   <= pick_wr ? wr_burst_len : rd_burst_len;
            op_wr   <= pick_wr;
`ifdef ARB_RR_EN
            last_wr <= pick_wr;
`endif
        end
    end

    // Refresh timer; a new due refresh wins over the clear from AREF
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else begin
            if (init_done)
                ref_cnt <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + RW'(1);
            if (init_done && ref_cnt == REF_LAST)
                ref_pend <= 1'b1;
            else if (state == S_REF)
                ref_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            sdram_rd_data <= '0;
        else
            sdram_rd_data <= sdram_dq_in;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (init_done && ref_pend)
                    state_nx = S_REF;
                else if (grant)
                    state_nx = S_ACT;
            end
            S_REF:   state_nx = S_REF_W;
            S_REF_W: if (cnt == RC_LAST) state_nx = S_IDLE;
            S_ACT:   state_nx = S_RCD_W;
            S_RCD_W: if (cnt == RCD_LAST) state_nx = op_wr ? S_WR : S_RD;
            S_WR:    if (cnt == len_m1) state_nx = S_BST;
            S_BST:   state_nx = S_PRE;
            S_RD:    state_nx = S_RD_W;
            S_RD_W:  if (cnt == CAS + len_m1) state_nx = S_PRE;
            S_PRE:   state_nx = S_PRE_W;
            S_PRE_W: if (cnt == RP_LAST) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Read acks line up with the registered data: CAS_LAT+1 after RD
    always_comb begin
        sdram_cmd    = CMD_NOP;
        sdram_ba     = 2'd0;
        sdram_a      = 13'd0;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        sdram_dq_oe  = 1'b0;
        unique case (state)
            S_REF: sdram_cmd = CMD_REF;
            S_ACT: begin
                sdram_cmd = CMD_ACT;
                sdram_ba  = addr_q[23:22];
                sdram_a   = addr_q[21:9];
            end
            S_RCD_W: sdram_wr_ack = op_wr && (cnt == RCD_LAST);
            S_WR: begin
                sdram_dq_oe  = 1'b1;
                sdram_wr_ack = (cnt != len_m1);
                if (cnt == 11'd0) begin
                    sdram_cmd = CMD_WR;
                    sdram_ba  = addr_q[23:22];
                    sdram_a   = {4'b0, addr_q[8:0]};
                end
            end
            S_BST: sdram_cmd = CMD_BST;
            S_RD: begin
                sdram_cmd = CMD_RD;
                sdram_ba  = addr_q[23:22];
                sdram_a   = {4'b0, addr_q[8:0]};
            end
            S_RD_W: begin
                if (cnt == len_m1)
                    sdram_cmd = CMD_BST;
                sdram_rd_ack = (cnt >= CAS) && (cnt <= CAS + len_m1);
            end
            S_PRE: begin
                sdram_cmd = CMD_PRE;
                sdram_a   = 13'h0400;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbit_resp.sv
// Randomized bench for sdram_arbit_resp against a transaction-schedule model.
// Honours ARB_RR_EN the same way as the design build.
module tb_sdram_arbit_resp;

    localparam int T_RCD   = 3;
    localparam int T_RP    = 3;
    localparam int T_RC    = 8;
    localparam int CAS     = 3;
    localparam int REF_PER = 750;
    localparam int NCYC    = 30000;
    localparam int MAXLEN  = 600;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_BST = 4'b0110;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic        wr_req = 1'b0;
    logic [23:0] wr_addr = '0;
    logic [9:0]  wr_len = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack;
    logic        rd_req = 1'b0;
    logic [23:0] rd_addr = '0;
    logic [9:0]  rd_len = '0;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic [15:0] dq_in = '0;
    logic [15:0] dq_out;
    logic        dq_oe;

    always #5 clk = ~clk;

    sdram_arbit_resp dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_done    (init_done),
        .sdram_wr_req (wr_req),
        .sdram_wr_addr(wr_addr),
        .wr_burst_len (wr_len),
        .sdram_wr_data(wr_data),
        .sdram_wr_ack (wr_ack),
        .sdram_rd_req (rd_req),
        .sdram_rd_addr(rd_addr),
        .rd_burst_len (rd_len),
        .sdram_rd_ack (rd_ack),
        .sdram_rd_data(rd_data),
        .sdram_cmd    (cmd),
        .sdram_ba     (ba),
        .sdram_a      (a),
        .sdram_dq_in  (dq_in),
        .sdram_dq_out (dq_out),
        .sdram_dq_oe  (dq_oe)
    );

    // chk: 0 none, 1 bank+address, 2 A10 only
    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] a;
        logic [1:0]  chk;
        logic        wack;
        logic        rack;
        logic        oe;
    } exp_t;

    exp_t plan[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h",
                     tag, cyc, got, exp);
        end
    endtask

    function automatic exp_t idle_rec();
        exp_t e;
        e = '0;
        e.cmd = C_NOP;
        return e;
    endfunction

    // Expected outputs for every cycle after the grant, from the timing rules
    function automatic void build(input bit is_wr, input logic [23:0] ad,
                                  input int len);
        int n, nn, m;
        exp_t e;
        nn = T_RCD;
        m  = T_RCD + 1;
        n  = is_wr ? T_RCD + len + T_RP + 1 : m + CAS + len + T_RP;
        for (int r = 1; r <= n; r++) begin
            e = idle_rec();
            if (r == 1) begin
                e.cmd = C_ACT; e.ba = ad[23:22]; e.a = ad[21:9]; e.chk = 2'd1;
            end
            if (is_wr) begin
                e.wack = (r >= nn) && (r <= nn + len - 1);
                e.oe   = (r >= nn + 1) && (r <= nn + len);
                if (r == nn + 1) begin
                    e.cmd = C_WR; e.ba = ad[23:22];
                    e.a = {4'b0, ad[8:0]}; e.chk = 2'd1;
                end
                if (r == nn + len + 1) e.cmd = C_BST;
                if (r == nn + len + 2) begin e.cmd = C_PRE; e.chk = 2'd2; end
            end else begin
                e.rack = (r >= m + CAS + 1) && (r <= m + CAS + len);
                if (r == m) begin
                    e.cmd = C_RD; e.ba = ad[23:22];
                    e.a = {4'b0, ad[8:0]}; e.chk = 2'd1;
                end
                if (r == m + len) e.cmd = C_BST;
                if (r == m + CAS + len + 1) begin e.cmd = C_PRE; e.chk = 2'd2; end
            end
            plan.push_back(e);
        end
    endfunction

    function automatic void build_ref();
        exp_t e;
        for (int r = 1; r <= T_RC; r++) begin
            e = idle_rec();
            if (r == 1) e.cmd = C_REF;
            plan.push_back(e);
        end
    endfunction

    function automatic logic [9:0] pick_len();
        int r;
        r = $urandom_range(99);
        if (r < 8)  return 10'd0;
        if (r < 12) return 10'd512;
        if (r < 14) return 10'($urandom_range(MAXLEN, 17));
        return 10'($urandom_range(16, 1));
    endfunction

    initial begin
        exp_t        e;
        bit          idle, set, wok, rok, w;
        int          timer, last_ref, max_gap, n_ref, kind;
        bit          pend, last_w, rst_q, wr_gr, rd_gr, did_reset;
        logic [15:0] dq_prev;
        timer = 0; pend = 0; last_w = 0; rst_q = 1; dq_prev = '0;
        last_ref = -1; max_gap = 0; n_ref = 0; kind = 0;
        wr_gr = 0; rd_gr = 0; did_reset = 0;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            idle = (plan.size() == 0);
            e = idle ? idle_rec() : plan.pop_front();

            check("cmd", 32'(cmd), 32'(e.cmd));
            check("ack_oe", 32'({wr_ack, rd_ack, dq_oe}),
                  32'({e.wack, e.rack, e.oe}));
            if (e.chk == 2'd1) check("ba_a", 32'({ba, a}), 32'({e.ba, e.a}));
            if (e.chk == 2'd2) check("pre_a10", 32'(a[10]), 32'd1);
            check("rd_data", 32'(rd_data), rst_q ? 32'd0 : 32'(dq_prev));
            if (e.oe) check("dq_out", 32'(dq_out), 32'(wr_data));

            if (cmd == C_REF) begin
                if (last_ref >= 0 && cyc - last_ref > max_gap)
                    max_gap = cyc - last_ref;
                last_ref = cyc;
                n_ref++;
            end

            // Stimulus for the rest of this cycle
            wr_data = 16'($urandom);
            dq_in   = 16'($urandom);
            rst_n   = (cyc >= 3);
            if (cyc == 3) begin
                wr_req = 1; wr_addr = 24'h012345; wr_len = 10'd8;
                rd_req = 1; rd_addr = 24'($urandom); rd_len = 10'd4;
            end
            if (cyc == 40) init_done = 1;
            if (cyc > 40) begin
                if (wr_req && (wr_gr || wr_len == 0) && $urandom_range(3) == 0) begin
                    wr_req = 0; wr_gr = 0;
                end
                if (wr_gr && $urandom_range(3) == 0) begin
                    wr_addr = 24'($urandom); wr_len = pick_len(); wr_gr = 0;
                end
                if (!wr_req && $urandom_range(7) == 0) begin
                    wr_req = 1; wr_addr = 24'($urandom); wr_len = pick_len();
                end
                if (rd_req && (rd_gr || rd_len == 0) && $urandom_range(3) == 0) begin
                    rd_req = 0; rd_gr = 0;
                end
                if (rd_gr && $urandom_range(3) == 0) begin
                    rd_addr = 24'($urandom); rd_len = pick_len(); rd_gr = 0;
                end
                if (!rd_req && $urandom_range(7) == 0) begin
                    rd_req = 1; rd_addr = 24'($urandom); rd_len = pick_len();
                end
            end
            if (!did_reset && cyc >= 15000 && kind == 2 &&
                plan.size() > 2 && plan.size() < 8) begin
                rst_n = 0;
                did_reset = 1;
            end

            // Model: what the edge ending this cycle does
            if (!rst_n) begin
                plan.delete();
                timer = 0; pend = 0; last_w = 0; last_ref = -1; kind = 0;
            end else begin
                set = 0;
                if (init_done) begin
                    if (timer == REF_PER - 1) begin timer = 0; set = 1; end
                    else timer++;
                end
                if (idle && init_done) begin
                    wok = wr_req && (wr_len != 0);
                    rok = rd_req && (rd_len != 0);
                    if (pend) begin
                        build_ref();
                        kind = 3;
                    end else if (wok || rok) begin
`ifdef ARB_RR_EN
                        w = wok && (!rok || !last_w);
`else
                        w = wok;
`endif
                        build(w, w ? wr_addr : rd_addr, w ? int'(wr_len) : int'(rd_len));
                        last_w = w;
                        kind = w ? 1 : 2;
                        if (w) wr_gr = 1; else rd_gr = 1;
                    end
                end
                pend = set | (pend & (e.cmd != C_REF));
            end
            rst_q   = !rst_n;
            dq_prev = dq_in;
        end

        check("ref_seen", 32'(n_ref > 20), 32'd1);
        check("ref_gap", 32'(max_gap <= REF_PER + T_RCD + 1 + CAS + MAXLEN + T_RP + T_RC),
              32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
